// File: rtl/sdot_dma_sequencer.sv
// sdot_dma_sequencer: CPU-programmed sequencer that streams the X then Y vector from memory
// into the SDOT accelerator, then fetches and latches the dot product for the CPU.
// Latency: 2 cycles per element without stalls; 4*LEN+1 cycles from the start write to done.
// Backpressure: each request is held with address/data stable while its waitrequest is high.
//
// Optional feature macro: SDOT_SEQ_IRQ_EN
//   defined   -> irq = irq_en & (done | err), CTRL[1] stores and reads back irq_en
//   undefined -> irq tied low, CTRL[1] reads back 0, completion is found by polling STATUS
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   s_*               Avalon-MM slave (CPU register access), s_readdata registered
//   mem_*             Avalon-MM read master towards vector memory (byte addresses)
//   acc_*             Avalon-MM master towards the accelerator (element writes, result read)
//   irq               done/error interrupt level
//
// Register map (word address)
//   0 CTRL   [0] start (write-1 pulse, reads 0), [1] irq_en
//   1 STATUS [0] busy, [1] done, [2] err   (write 1 to [2:1] clears)
//   2 X_BASE  3 Y_BASE  4 LEN[7:0]  5 RESULT (RO)  6,7 read 0
module sdot_dma_sequencer #(
    parameter int unsigned MAX_LEN       = 96,
    parameter logic [23:0] ACC_DATA_ADDR = 24'h000000,
    parameter logic [23:0] ACC_RES_ADDR  = 24'h000000
) (
    input  logic        clk,
    input  logic        reset,
    // CPU slave
    input  logic [2:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write,
    input  logic        s_read,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    // memory read master
    output logic [31:0] mem_address,
    output logic        mem_read,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest,
    // accelerator master
    output logic [23:0] acc_address,
    output logic        acc_write,
    output logic        acc_read,
    output logic [31:0] acc_writedata,
    input  logic [31:0] acc_readdata,
    input  logic        acc_waitrequest,
    // interrupt
    output logic        irq
);

    // ------------------------------------------------------------------
    // State and register address encodings
    // ------------------------------------------------------------------
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_X    = 3'd1;
    localparam logic [2:0] S_WR_X    = 3'd2;
    localparam logic [2:0] S_RD_Y    = 3'd3;
    localparam logic [2:0] S_WR_Y    = 3'd4;
    localparam logic [2:0] S_GET_RES = 3'd5;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_STATUS = 3'd1;
    localparam logic [2:0] A_XBASE  = 3'd2;
    localparam logic [2:0] A_YBASE  = 3'd3;
    localparam logic [2:0] A_LEN    = 3'd4;
    localparam logic [2:0] A_RESULT = 3'd5;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]  r_state;
    logic [7:0]  r_idx;
    logic [31:0] r_data;      // element captured from memory, replayed to the accelerator
    logic [31:0] r_x_base;
    logic [31:0] r_y_base;
    logic [7:0]  r_len;
    logic [31:0] r_result;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_readdata;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic        w_cpu_wr;
    logic        w_cpu_rd;
    logic        w_start_req;
    logic        w_len_ok;
    logic        w_go;
    logic        w_reject;
    logic        w_w1c_done;
    logic        w_w1c_err;
    logic        w_cfg_wr;
    logic        w_rd_phase;
    logic        w_wr_phase;
    logic        w_res_phase;
    logic        w_res_ack;
    logic        w_last;
    logic [31:0] w_elem_off;
    logic [31:0] w_rd_mux;
    logic        w_irq_en;

    assign w_cpu_wr = s_chipselect & s_write;
    assign w_cpu_rd = s_chipselect & s_read;

    // A start is only honoured while idle; a start during a run is dropped.
    assign w_start_req = w_cpu_wr && (s_address == A_CTRL) && s_writedata[0]
                         && (r_state == S_IDLE);
    assign w_len_ok    = (r_len != 8'd0) && (32'(r_len) <= MAX_LEN);
    assign w_go        = w_start_req & w_len_ok;
    assign w_reject    = w_start_req & ~w_len_ok;

    assign w_w1c_done  = w_cpu_wr && (s_address == A_STATUS) && s_writedata[1];
    assign w_w1c_err   = w_cpu_wr && (s_address == A_STATUS) && s_writedata[2];

    // Base/length registers are frozen for the whole run.
    assign w_cfg_wr    = w_cpu_wr & ~r_busy;

    assign w_rd_phase  = (r_state == S_RD_X) || (r_state == S_RD_Y);
    assign w_wr_phase  = (r_state == S_WR_X) || (r_state == S_WR_Y);
    assign w_res_phase = (r_state == S_GET_RES);
    assign w_res_ack   = w_res_phase & ~acc_waitrequest;

    // LEN is known to be >= 1 whenever a write phase is active, so LEN-1 never wraps.
    assign w_last      = (r_idx == (r_len - 8'd1));

    // Byte offset of the current element; the base add wraps modulo 2^32.
    assign w_elem_off  = {22'h0, r_idx, 2'b00};

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_idx    <= 8'd0;
            r_data   <= 32'h0;
            r_result <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_idx   <= 8'd0;
                        r_state <= S_RD_X;
                    end
                end
                S_RD_X: begin
                    if (!mem_waitrequest) begin
                        r_data  <= mem_readdata;
                        r_state <= S_WR_X;
                    end
                end
                S_WR_X: begin
                    if (!acc_waitrequest) begin
                        if (w_last) begin
                            r_idx   <= 8'd0;
                            r_state <= S_RD_Y;
                        end else begin
                            r_idx   <= r_idx + 8'd1;
                            r_state <= S_RD_X;
                        end
                    end
                end
                S_RD_Y: begin
                    if (!mem_waitrequest) begin
                        r_data  <= mem_readdata;
                        r_state <= S_WR_Y;
                    end
                end
                S_WR_Y: begin
                    if (!acc_waitrequest) begin
                        if (w_last) begin
                            r_idx   <= 8'd0;
                            r_state <= S_GET_RES;
                        end else begin
                            r_idx   <= r_idx + 8'd1;
                            r_state <= S_RD_Y;
                        end
                    end
                end
                S_GET_RES: begin
                    if (!acc_waitrequest) begin
                        r_result <= acc_readdata;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // STATUS bits
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_go) begin
                r_busy <= 1'b1;
            end else if (w_res_ack) begin
                r_busy <= 1'b0;
            end

            // Hardware completion takes priority over a simultaneous CPU clear.
            if (w_go) begin
                r_done <= 1'b0;
            end else if (w_res_ack) begin
                r_done <= 1'b1;
            end else if (w_w1c_done) begin
                r_done <= 1'b0;
            end

            if (w_go) begin
                r_err <= 1'b0;
            end else if (w_reject) begin
                r_err <= 1'b1;
            end else if (w_w1c_err) begin
                r_err <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x_base <= 32'h0;
            r_y_base <= 32'h0;
            r_len    <= 8'd0;
        end else if (w_cfg_wr) begin
            case (s_address)
                A_XBASE: r_x_base <= s_writedata;
                A_YBASE: r_y_base <= s_writedata;
                A_LEN:   r_len    <= s_writedata[7:0];
                default: ;
            endcase
        end
    end

`ifdef SDOT_SEQ_IRQ_EN
    logic r_irq_en;

    // irq_en may be changed at any time, including mid-run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_en <= 1'b0;
        end else if (w_cpu_wr && (s_address == A_CTRL)) begin
            r_irq_en <= s_writedata[1];
        end
    end

    assign w_irq_en = r_irq_en;
    assign irq      = r_irq_en & (r_done | r_err);
`else
    assign w_irq_en = 1'b0;
    assign irq      = 1'b0;
`endif

    // ------------------------------------------------------------------
    // CPU read path
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_mux = 32'h0;
        case (s_address)
            A_CTRL:   w_rd_mux = {30'h0, w_irq_en, 1'b0};
            A_STATUS: w_rd_mux = {29'h0, r_err, r_done, r_busy};
            A_XBASE:  w_rd_mux = r_x_base;
            A_YBASE:  w_rd_mux = r_y_base;
            A_LEN:    w_rd_mux = {24'h0, r_len};
            A_RESULT: w_rd_mux = r_result;
            default:  w_rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= 32'h0;
        end else if (w_cpu_rd) begin
            r_readdata <= w_rd_mux;
        end
    end

    assign s_readdata = r_readdata;

    // ------------------------------------------------------------------
    // Bus requests: decoded straight from the state register so that an
    // asynchronous reset drops them without waiting for a clock edge.
    // The state encoding guarantees only one request is ever active.
    // ------------------------------------------------------------------
    assign mem_read      = w_rd_phase;
    assign mem_address   = (r_state == S_RD_X) ? (r_x_base + w_elem_off) :
                           (r_state == S_RD_Y) ? (r_y_base + w_elem_off) : 32'h0;

    assign acc_write     = w_wr_phase;
    assign acc_read      = w_res_phase;
    assign acc_writedata = w_wr_phase ? r_data : 32'h0;
    assign acc_address   = w_wr_phase  ? ACC_DATA_ADDR :
                           w_res_phase ? ACC_RES_ADDR  : 24'h0;

endmodule

// File: tb/tb_sdot_dma_sequencer.sv
`timescale 1ns/1ps
module tb_sdot_dma_sequencer;

    localparam int MAXL = 96;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  s_address;
    logic        s_chipselect;
    logic        s_write;
    logic        s_read;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;
    logic [23:0] acc_address;
    logic        acc_write;
    logic        acc_read;
    logic [31:0] acc_writedata;
    logic [31:0] acc_readdata;
    logic        acc_waitrequest;
    logic        irq;

    always #5 clk = ~clk;

    sdot_dma_sequencer dut (
        .clk(clk), .reset(reset),
        .s_address(s_address), .s_chipselect(s_chipselect), .s_write(s_write),
        .s_read(s_read), .s_writedata(s_writedata), .s_readdata(s_readdata),
        .mem_address(mem_address), .mem_read(mem_read), .mem_readdata(mem_readdata),
        .mem_waitrequest(mem_waitrequest),
        .acc_address(acc_address), .acc_write(acc_write), .acc_read(acc_read),
        .acc_writedata(acc_writedata), .acc_readdata(acc_readdata),
        .acc_waitrequest(acc_waitrequest), .irq(irq)
    );

    // ---------------- environment models ----------------
    logic [31:0] mem_arr [0:1023];          // 4 KB memory window, address bits [11:2]
    assign mem_readdata = mem_arr[mem_address[11:2]];

    bit          stall_en, mem_wr_rnd, acc_wr_rnd, acc_force, mon_en;
    logic [31:0] acc_res;
    assign mem_waitrequest = mem_wr_rnd;
    assign acc_waitrequest = acc_wr_rnd | acc_force;
    assign acc_readdata    = acc_res;

    initial forever begin
        @(posedge clk); #1;
        mem_wr_rnd = stall_en && ($urandom_range(2) == 0);
        acc_wr_rnd = stall_en && ($urandom_range(2) == 0);
    end

    typedef struct packed { logic [2:0] kind; logic [31:0] addr; logic [31:0] data; } req_t;
    localparam logic [2:0] K_MEM = 3'b100, K_WR = 3'b010, K_RES = 3'b001;

    req_t        exp_q[$];                  // expected bus transactions, in order
    logic [31:0] recv[$];                   // elements the accelerator has accepted
    int          xv[MAXL], yv[MAXL];
    int          cur_len;
    logic [31:0] exp_result;
    int          n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b; int e;
        if (r == 0.0) return 32'h0;
        b = $realtobits(r);
        e = int'(b[62:52]) - 1023 + 127;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] b; int e;
        if (f[30:23] == 8'h0) return 0.0;
        e = int'(f[30:23]) - 127 + 1023;
        b = {f[31], e[10:0], f[22:0], 29'h0};
        return $bitstoreal(b);
    endfunction

    function automatic logic irq_model(input bit ien, input bit flag);
`ifdef SDOT_SEQ_IRQ_EN
        return ien & flag;
`else
        return 1'b0;
`endif
    endfunction

    function automatic req_t mk_req(input logic [2:0] k, input logic [31:0] a, input logic [31:0] d);
        req_t r;
        r.kind = k; r.addr = a; r.data = d;
        return r;
    endfunction

    // Per-cycle compare: whatever request is on the buses must be the head of
    // the expected transaction list; with nothing expected the buses must be quiet.
    always @(negedge clk) begin
        logic [2:0] req;
        req_t       h;
        real        s;
        if (mon_en) begin
            req = {mem_read, acc_write, acc_read};
            if (exp_q.size() == 0) begin
                chk("idle_no_request", {29'h0, req}, 32'h0);
            end else begin
                h = exp_q[0];
                chk("request_kind", {29'h0, req}, {29'h0, h.kind});
                if (h.kind == K_MEM) begin
                    chk("mem_address", mem_address, h.addr);
                    if (mem_read && !mem_waitrequest) void'(exp_q.pop_front());
                end else if (h.kind == K_WR) begin
                    chk("acc_wr_address", {8'h0, acc_address}, h.addr);
                    chk("acc_writedata", acc_writedata, h.data);
                    if (acc_write && !acc_waitrequest) begin
                        void'(exp_q.pop_front());
                        recv.push_back(acc_writedata);
                        if (recv.size() == 2 * cur_len) begin
                            s = 0.0;
                            for (int i = 0; i < cur_len; i++)
                                s = s + f2r(recv[i]) * f2r(recv[cur_len + i]);
                            acc_res = r2f(s);
                        end
                    end
                end else begin
                    chk("acc_rd_address", {8'h0, acc_address}, h.addr);
                    if (acc_read && !acc_waitrequest) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- CPU access tasks ----------------
    task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        s_chipselect = 1'b1; s_write = 1'b1; s_address = a; s_writedata = d;
        @(posedge clk); #1;
        s_chipselect = 1'b0; s_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        s_chipselect = 1'b1; s_read = 1'b1; s_address = a;
        @(posedge clk); #1;
        s_chipselect = 1'b0; s_read = 1'b0;
        d = s_readdata;
    endtask

    // pattern 0: X = 1..len, Y = 1; pattern 1: small random integers
    task automatic setup_job(input logic [31:0] xb, input logic [31:0] yb, input int len, input int pattern);
        int sum; logic [31:0] a;
        sum = 0; cur_len = len;
        for (int i = 0; i < len; i++) begin
            xv[i] = (pattern == 0) ? i + 1 : int'($urandom_range(15));
            yv[i] = (pattern == 0) ? 1     : int'($urandom_range(15));
            sum += xv[i] * yv[i];
            a = xb + 32'(4 * i); mem_arr[a[11:2]] = r2f(real'(xv[i]));
            a = yb + 32'(4 * i); mem_arr[a[11:2]] = r2f(real'(yv[i]));
        end
        exp_result = r2f(real'(sum));
        cpu_write(3'd4, 32'(len));
        cpu_write(3'd2, xb);
        cpu_write(3'd3, yb);
    endtask

    task automatic start_job(input logic [31:0] xb, input logic [31:0] yb, input bit ien);
        recv.delete();
        acc_res = 32'hDEADBEEF;
        cpu_write(3'd0, {30'h0, ien, 1'b1});
        for (int i = 0; i < cur_len; i++) begin
            exp_q.push_back(mk_req(K_MEM, xb + 32'(4 * i), 32'h0));
            exp_q.push_back(mk_req(K_WR, 32'h0, r2f(real'(xv[i]))));
        end
        for (int i = 0; i < cur_len; i++) begin
            exp_q.push_back(mk_req(K_MEM, yb + 32'(4 * i), 32'h0));
            exp_q.push_back(mk_req(K_WR, 32'h0, r2f(real'(yv[i]))));
        end
        exp_q.push_back(mk_req(K_RES, 32'h0, 32'h0));
    endtask

    // Counts edges from the start-write edge to the edge that accepts the result read.
    task automatic wait_done(output int cyc);
        bit acc, ok;
        cyc = 0; ok = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk); acc = acc_read && !acc_waitrequest;
            @(posedge clk); cyc++;
            if (acc) begin ok = 1'b1; break; end
        end
        #1;
        chk("done_within_bound", {31'h0, ok}, 32'h1);
    endtask

    task automatic finish_check(input bit ien);
        logic [31:0] d;
        cpu_read(3'd1, d); chk("status_done", d, 32'h2);
        cpu_read(3'd5, d); chk("result", d, exp_result);
        chk("irq_on_done", {31'h0, irq}, {31'h0, irq_model(ien, 1'b1)});
        cpu_read(3'd0, d); chk("ctrl_readback", d, {30'h0, irq_model(ien, 1'b1), 1'b0});
        cpu_write(3'd1, 32'h6);
        cpu_read(3'd1, d); chk("status_cleared", d, 32'h0);
        chk("irq_cleared", {31'h0, irq}, 32'h0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] d, xb, yb;
        int cyc, len;
        bit ien, ok;
        reset = 1'b1; s_address = 3'd0; s_chipselect = 1'b0; s_write = 1'b0;
        s_read = 1'b0; s_writedata = 32'h0; acc_force = 1'b0; stall_en = 1'b0;
        mon_en = 1'b0; acc_res = 32'h0;
        for (int i = 0; i < 1024; i++) mem_arr[i] = 32'h0;
        #1;
        chk("rst_mem_read", {31'h0, mem_read}, 32'h0);
        chk("rst_acc_write", {31'h0, acc_write}, 32'h0);
        chk("rst_acc_read", {31'h0, acc_read}, 32'h0);
        chk("rst_mem_address", mem_address, 32'h0);
        chk("rst_acc_address", {8'h0, acc_address}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_readdata", s_readdata, 32'h0);
        chk("pin_float_one", r2f(1.0), 32'h3F800000);
        chk("pin_float_ten", r2f(10.0), 32'h41200000);
        repeat (3) @(negedge clk);
        reset = 1'b0; mon_en = 1'b1;
        for (int a = 0; a < 8; a++) begin
            cpu_read(3'(a), d); chk("reset_reg_zero", d, 32'h0);
        end
        cpu_write(3'd6, 32'hFFFFFFFF);
        cpu_read(3'd6, d); chk("reg6_reads_zero", d, 32'h0);
        cpu_read(3'd7, d); chk("reg7_reads_zero", d, 32'h0);

        // 1: reference vector, no stalls
        setup_job(32'h100, 32'h200, 4, 0);
        chk("t1_model_result", exp_result, 32'h41200000);
        start_job(32'h100, 32'h200, 1'b1);
        wait_done(cyc);
        chk("t1_latency", 32'(cyc), 32'd17);
        finish_check(1'b1);

        // 2: same with random stalls on both masters
        stall_en = 1'b1;
        setup_job(32'h100, 32'h200, 4, 0);
        start_job(32'h100, 32'h200, 1'b1);
        wait_done(cyc);
        finish_check(1'b1);
        stall_en = 1'b0;

        // done set and CPU clear land on the same edge: set wins
        setup_job(32'h300, 32'h380, 2, 1);
        start_job(32'h300, 32'h380, 1'b0);
        repeat (7) @(posedge clk);
        cpu_write(3'd1, 32'h6);
        cpu_read(3'd1, d); chk("set_wins_status", d, 32'h2);
        cpu_read(3'd5, d); chk("set_wins_result", d, exp_result);
        cpu_write(3'd1, 32'h6);
        cpu_read(3'd1, d); chk("set_wins_cleared", d, 32'h0);

        // 3: illegal lengths flag err without bus activity
        cpu_write(3'd4, 32'd0);
        cpu_write(3'd0, 32'h1);
        repeat (5) @(posedge clk);
        cpu_read(3'd1, d); chk("len0_err", d, 32'h4);
        chk("len0_irq", {31'h0, irq}, 32'h0);
        cpu_write(3'd1, 32'h4);
        cpu_read(3'd1, d); chk("len0_err_cleared", d, 32'h0);
        cpu_write(3'd4, 32'd97);
        cpu_read(3'd4, d); chk("len97_readback", d, 32'd97);
        cpu_write(3'd0, 32'h3);
        repeat (5) @(posedge clk);
        cpu_read(3'd1, d); chk("len97_err", d, 32'h4);
        chk("len97_irq", {31'h0, irq}, {31'h0, irq_model(1'b1, 1'b1)});
        cpu_write(3'd1, 32'h4);
        cpu_read(3'd1, d); chk("len97_err_cleared", d, 32'h0);
        chk("len97_irq_cleared", {31'h0, irq}, 32'h0);

        // randomized jobs, including LEN=96, LEN=1 and an address wrap
        for (int j = 0; j < 6; j++) begin
            len = (j == 0) ? 96 : (j == 1) ? 1 : int'($urandom_range(40, 2));
            xb  = (j == 2) ? 32'hFFFFFFF8 : 32'($urandom_range(32'h5FF));
            yb  = xb + 32'h800;
            stall_en = (j >= 3);
            ien = 1'($urandom_range(1));
            setup_job(xb, yb, len, 1);
            start_job(xb, yb, ien);
            wait_done(cyc);
            if (!stall_en) chk("rand_latency", 32'(cyc), 32'(4 * len + 1));
            finish_check(ien);
        end

        // 4: configuration writes and restart while busy are ignored
        stall_en = 1'b1;
        setup_job(32'h40, 32'h840, 20, 1);
        start_job(32'h40, 32'h840, 1'b0);
        cpu_write(3'd2, 32'h12345678);
        cpu_write(3'd4, 32'd5);
        cpu_write(3'd3, 32'hCAFE0000);
        cpu_write(3'd0, 32'h1);
        cpu_read(3'd2, d); chk("busy_xbase_kept", d, 32'h40);
        cpu_read(3'd1, d); chk("busy_status", d, 32'h1);
        wait_done(cyc);
        finish_check(1'b0);
        cpu_read(3'd2, d); chk("after_xbase", d, 32'h40);
        cpu_read(3'd3, d); chk("after_ybase", d, 32'h840);
        cpu_read(3'd4, d); chk("after_len", d, 32'd20);
        repeat (30) @(posedge clk);
        stall_en = 1'b0;

        // 5: reset while a Y element write is stalled
        setup_job(32'h500, 32'hD00, 3, 1);
        start_job(32'h500, 32'hD00, 1'b0);
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            if (acc_write && recv.size() == cur_len) begin ok = 1'b1; break; end
        end
        chk("t5_reach_wr_y", {31'h0, ok}, 32'h1);
        acc_force = 1'b1;
        @(negedge clk);
        mon_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("t5_acc_write_drop", {31'h0, acc_write}, 32'h0);
        chk("t5_mem_read_low", {31'h0, mem_read}, 32'h0);
        chk("t5_acc_read_low", {31'h0, acc_read}, 32'h0);
        chk("t5_acc_wdata_zero", acc_writedata, 32'h0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        acc_force = 1'b0;
        reset = 1'b0;
        mon_en = 1'b1;
        cpu_read(3'd1, d); chk("t5_status_zero", d, 32'h0);
        cpu_read(3'd5, d); chk("t5_result_zero", d, 32'h0);
        cpu_read(3'd4, d); chk("t5_len_zero", d, 32'h0);
        setup_job(32'h10, 32'h90, 1, 1);
        start_job(32'h10, 32'h90, 1'b1);
        wait_done(cyc);
        chk("t5_len1_latency", 32'(cyc), 32'd5);
        finish_check(1'b1);

        // 6: irq disabled stays low through completion
        setup_job(32'h600, 32'hE00, 3, 0);
        start_job(32'h600, 32'hE00, 1'b0);
        wait_done(cyc);
        chk("irq_off_low", {31'h0, irq}, 32'h0);
        finish_check(1'b0);

        repeat (5) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
